// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control defines: PC width, stage bit indices, stall/bubble patterns, FSM encodings.
// PIPE_PC_W may be overridden on the command line; it defaults to 32.
`ifndef PIPE_PC_W
`define PIPE_PC_W 32
`endif

package pipe_ctrl_pkg;

    localparam int unsigned PC_W  = `PIPE_PC_W;
    localparam int unsigned STG_W = 6;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned ST_W  = 2;

    localparam int unsigned STG_PC    = 5;
    localparam int unsigned STG_IFID  = 4;
    localparam int unsigned STG_IDEX  = 3;
    localparam int unsigned STG_EXMEM = 2;
    localparam int unsigned STG_MEMWB = 1;
    localparam int unsigned STG_WB    = 0;

    typedef logic [STG_W-1:0] stg_vec_t;

    // Each requester freezes its own stage and everything upstream; the next stage down takes the NOP.
    localparam stg_vec_t STALL_ID  = (stg_vec_t'(1) << STG_PC) | (stg_vec_t'(1) << STG_IFID)
                                   | (stg_vec_t'(1) << STG_IDEX);
    localparam stg_vec_t STALL_EX  = STALL_ID | (stg_vec_t'(1) << STG_EXMEM);
    localparam stg_vec_t STALL_MEM = STALL_EX | (stg_vec_t'(1) << STG_MEMWB);
    localparam stg_vec_t BUB_ID    = stg_vec_t'(1) << STG_EXMEM;
    localparam stg_vec_t BUB_EX    = stg_vec_t'(1) << STG_MEMWB;
    localparam stg_vec_t BUB_MEM   = stg_vec_t'(1) << STG_WB;

    localparam logic [ST_W-1:0] ST_RUN   = 2'b00;
    localparam logic [ST_W-1:0] ST_STALL = 2'b01;
    localparam logic [ST_W-1:0] ST_FLUSH = 2'b10;

endpackage

// File: rtl/stall_watchdog.sv
// Stall watchdog: saturating count of consecutive stalled cycles and a sticky timeout flag.
import pipe_ctrl_pkg::*;

module stall_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall_active_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_timeout;

    // Clear on any free cycle, hold at all-ones instead of wrapping.
    always_comb begin
        w_cnt_nxt = '0;
        if (stall_active_i) begin
            w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (stall_active_i && (w_cnt_nxt >= TMO)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/bubble resolution, one-cycle redirect flush, stall watchdog.
// Optional feature: define PIPE_STALL_CNT_EN to add the 32-bit total-stall-cycle counter stallCnt_o.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_stallReq_i,
    input  logic            ex_stallReq_i,
    input  logic            mem_stallReq_i,
    input  logic            flush_i,
    input  logic [PC_W-1:0] flushPc_i,
    output logic [STG_W-1:0] stall_o,
    output logic [STG_W-1:0] bubble_o,
    output logic            flush_o,
    output logic [PC_W-1:0] newPc_o,
`ifdef PIPE_STALL_CNT_EN
    output logic [31:0]     stallCnt_o,
`endif
    output logic            timeout_o
);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_state_nxt;
    logic            r_flush_o;
    logic [PC_W-1:0] r_new_pc;
    stg_vec_t        w_stall;
    stg_vec_t        w_bubble;
    logic            w_in_flush;
    logic            w_req_any;
    logic            w_stall_active;
    logic            w_timeout;

    assign w_in_flush     = (r_state == ST_FLUSH);
    assign w_req_any      = id_stallReq_i | ex_stallReq_i | mem_stallReq_i;
    assign w_stall_active = |w_stall;

    // Same-cycle stall resolution (mem > ex > id) and next state; the FLUSH cycle ignores all requests.
    always_comb begin
        w_stall     = '0;
        w_bubble    = '0;
        w_state_nxt = r_state;
        if (rst_n && !w_in_flush) begin
            if (mem_stallReq_i) begin
                w_stall  = STALL_MEM;
                w_bubble = BUB_MEM;
            end else if (ex_stallReq_i) begin
                w_stall  = STALL_EX;
                w_bubble = BUB_EX;
            end else if (id_stallReq_i) begin
                w_stall  = STALL_ID;
                w_bubble = BUB_ID;
            end
        end
        case (r_state)
            ST_FLUSH: w_state_nxt = ST_RUN;
            default: begin
                if (flush_i) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_req_any) begin
                    w_state_nxt = ST_STALL;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_flush_o <= 1'b0;
            r_new_pc  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_flush_o <= (w_state_nxt == ST_FLUSH);
            if (flush_i && !w_in_flush) begin
                r_new_pc <= flushPc_i;
            end
        end
    end

    stall_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_stall_watchdog (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_active_i(w_stall_active),
        .timeout_o     (w_timeout)
    );

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Lifetime stall-cycle total; wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_active) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stallCnt_o = r_stall_cnt;
`endif

    assign stall_o   = w_stall;
    assign bubble_o  = w_bubble;
    assign flush_o   = r_flush_o;
    assign newPc_o   = r_new_pc;
    assign timeout_o = w_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (TIMEOUT=4).
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_req;
    logic        ex_req;
    logic        mem_req;
    logic        flush;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic [5:0]  bubble;
    logic        flush_out;
    logic [31:0] new_pc;
    logic        timeout;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    pipe_ctrl #(
        .TIMEOUT(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_stallReq_i (id_req),
        .ex_stallReq_i (ex_req),
        .mem_stallReq_i(mem_req),
        .flush_i       (flush),
        .flushPc_i     (flush_pc),
        .stall_o       (stall),
        .bubble_o      (bubble),
        .flush_o       (flush_out),
        .newPc_o       (new_pc),
`ifdef PIPE_STALL_CNT_EN
        .stallCnt_o    (stall_cnt),
`endif
        .timeout_o     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge; checks follow at the falling edge.
    task automatic cyc(input logic id, input logic ex, input logic mem,
                       input logic fl, input logic [31:0] pc);
        @(posedge clk);
        #1;
        id_req   = id;
        ex_req   = ex;
        mem_req  = mem;
        flush    = fl;
        flush_pc = pc;
        @(negedge clk);
    endtask

    task automatic chk_sb(input string tag, input logic [5:0] s, input logic [5:0] b);
        chk({tag, ".stall"}, 32'(stall), 32'(s));
        chk({tag, ".bubble"}, 32'(bubble), 32'(b));
    endtask

    initial begin
        rst_n    = 1'b0;
        id_req   = 1'b1;
        ex_req   = 1'b0;
        mem_req  = 1'b1;
        flush    = 1'b0;
        flush_pc = 32'h0;
        #12;
        chk_sb("rst", 6'b000000, 6'b000000);
        chk("rst.flush", 32'(flush_out), 32'd0);
        chk("rst.newpc", new_pc, 32'h0);
        chk("rst.timeout", 32'(timeout), 32'd0);
        id_req  = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // id stall for two cycles
        cyc(1, 0, 0, 0, 0);  chk_sb("id1", 6'b111000, 6'b000100);
        cyc(1, 0, 0, 0, 0);  chk_sb("id2", 6'b111000, 6'b000100);
        cyc(0, 0, 0, 0, 0);  chk_sb("id3", 6'b000000, 6'b000000);

        // priority mem > ex > id
        cyc(1, 1, 1, 0, 0);  chk_sb("pri_all", 6'b111110, 6'b000001);
        cyc(1, 1, 0, 0, 0);  chk_sb("pri_ex", 6'b111100, 6'b000010);
        cyc(0, 0, 0, 0, 0);  chk_sb("pri_none", 6'b000000, 6'b000000);

        // flush to 0x40; requests and a second flush in the FLUSH cycle are ignored
        cyc(0, 0, 0, 1, 32'h40);
        chk("fl.req_cycle", 32'(flush_out), 32'd0);
        cyc(1, 0, 0, 1, 32'h80);
        chk("fl.flush", 32'(flush_out), 32'd1);
        chk("fl.newpc", new_pc, 32'h40);
        chk_sb("fl.cyc", 6'b000000, 6'b000000);
        cyc(1, 0, 0, 0, 0);
        chk("fl.after", 32'(flush_out), 32'd0);
        chk("fl.newpc_hold", new_pc, 32'h40);
        chk_sb("fl.after", 6'b111000, 6'b000100);
        cyc(0, 0, 0, 0, 0);
        chk("fl.once", 32'(flush_out), 32'd0);

        // flush while mem stall held three cycles
        cyc(0, 0, 1, 1, 32'h100);
        chk_sb("fm1", 6'b111110, 6'b000001);
        cyc(0, 0, 1, 0, 0);
        chk_sb("fm2", 6'b000000, 6'b000000);
        chk("fm2.flush", 32'(flush_out), 32'd1);
        chk("fm2.newpc", new_pc, 32'h100);
        cyc(0, 0, 1, 0, 0);
        chk_sb("fm3", 6'b111110, 6'b000001);
        chk("fm3.flush", 32'(flush_out), 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("pre_tmo", 32'(timeout), 32'd0);

        // watchdog: four consecutive stalled edges trip the sticky flag
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0, 0);
            chk($sformatf("tmo.low%0d", i), 32'(timeout), 32'd0);
        end
        cyc(0, 0, 0, 0, 0);
        chk("tmo.set", 32'(timeout), 32'd1);
        cyc(0, 0, 0, 0, 0);
        chk("tmo.sticky", 32'(timeout), 32'd1);
`ifdef PIPE_STALL_CNT_EN
        chk("stallcnt", stall_cnt, 32'd11);
`endif

        // reset pulsed in the middle of a FLUSH cycle
        cyc(0, 0, 0, 1, 32'h200);
        cyc(1, 0, 0, 0, 0);
        chk("rf.flush_pre", 32'(flush_out), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rf.flush", 32'(flush_out), 32'd0);
        chk("rf.newpc", new_pc, 32'h0);
        chk("rf.timeout", 32'(timeout), 32'd0);
        chk_sb("rf", 6'b000000, 6'b000000);
`ifdef PIPE_STALL_CNT_EN
        chk("rf.stallcnt", stall_cnt, 32'd0);
`endif
        id_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("rf.no_flush", 32'(flush_out), 32'd0);
        chk("rf.newpc_post", new_pc, 32'h0);
        cyc(0, 1, 0, 0, 0);
        chk_sb("rf.run", 6'b111100, 6'b000010);
        cyc(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
